// File: rtl/bcr_pkg.sv
// Shared types and constants for the 8-lane bank-conflict-resolver dispatcher.
// Imported by bcr_bank_fifo and bcr_bank_dispatcher_x8.
package bcr_pkg;

  localparam int LANES     = 8;
  localparam int EDGE_W    = 96;
  localparam int BANK_W    = 3;
  localparam int NUM_BANKS = 1 << BANK_W;

  typedef logic [EDGE_W-1:0] edge_t;
  typedef logic [BANK_W-1:0] bank_idx_t;

  function automatic bank_idx_t bank_of(input edge_t e);
    return e[BANK_W-1:0];
  endfunction

endpackage

// File: rtl/bcr_bank_fifo.sv
// First-word-fall-through FIFO for one memory bank.
// A write into a full FIFO is taken only when a pop happens in the same cycle.
module bcr_bank_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             rd_fire;
  logic             wr_fire;

  always_comb begin
    rd_fire  = rd_en && (count_q != '0);
    wr_fire  = wr_en && ((count_q != CNT_W'(DEPTH)) || rd_fire);
    wr_ptr_d = wr_fire ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = rd_fire ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(wr_fire) - CNT_W'(rd_fire);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; emptiness is tracked solely by the counters.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign count   = count_q;
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/bcr_bank_dispatcher_x8.sv
// Routes the 8 resolver lanes into per-bank FWFT FIFOs, generates stall and counts edges.
// Optional lane-pair conflict detection is enabled by defining BCR_DISPATCH_CONFLICT_CHECK_EN.
module bcr_bank_dispatcher_x8
  import bcr_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int STALL_MARGIN = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [LANES*EDGE_W-1:0]       lane_data,
  input  logic [LANES-1:0]              lane_valid,
  output logic                          stall,
  output logic [NUM_BANKS*EDGE_W-1:0]   bank_data,
  output logic [NUM_BANKS-1:0]          bank_valid,
  input  logic [NUM_BANKS-1:0]          bank_ready,
  output logic [31:0]                   edges_accepted,
  output logic                          overflow_err,
  output logic                          conflict_err
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  edge_t                lane_edge   [LANES];
  edge_t                wr_edge     [NUM_BANKS];
  edge_t                fifo_data   [NUM_BANKS];
  logic [CNT_W-1:0]     fifo_count  [NUM_BANKS];
  logic [NUM_BANKS-1:0] wr_req;
  logic [NUM_BANKS-1:0] wr_accept;
  logic [NUM_BANKS-1:0] rd_pop;
  logic [NUM_BANKS-1:0] fifo_empty;
  logic [NUM_BANKS-1:0] fifo_full;
  logic [3:0]           accept_cnt;
  logic                 overflow_hit;

  logic [31:0] edges_accepted_q, edges_accepted_d;
  logic        overflow_err_q, overflow_err_d;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane_edge[i] = lane_data[EDGE_W*i +: EDGE_W];
    end
  end

  // Scanning from the top lane down leaves the lowest-index match as the winner.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      wr_req[b]  = 1'b0;
      wr_edge[b] = '0;
      for (int i = LANES - 1; i >= 0; i--) begin
        if (lane_valid[i] && (bank_of(lane_edge[i]) == bank_idx_t'(b))) begin
          wr_req[b]  = 1'b1;
          wr_edge[b] = lane_edge[i];
        end
      end
    end
  end

  assign bank_valid = ~fifo_empty;
  assign rd_pop     = bank_valid & bank_ready;
  assign wr_accept  = wr_req & (~fifo_full | rd_pop);

  always_comb begin
    accept_cnt   = '0;
    overflow_hit = 1'b0;
    stall        = 1'b0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      accept_cnt   = accept_cnt + 4'(wr_accept[b]);
      overflow_hit = overflow_hit | (wr_req[b] & fifo_full[b] & ~rd_pop[b]);
      stall        = stall | (fifo_count[b] >= CNT_W'(DEPTH - STALL_MARGIN));
    end
    edges_accepted_d = edges_accepted_q + 32'(accept_cnt);
    overflow_err_d   = overflow_err_q | overflow_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      edges_accepted_q <= '0;
      overflow_err_q   <= 1'b0;
    end else begin
      edges_accepted_q <= edges_accepted_d;
      overflow_err_q   <= overflow_err_d;
    end
  end

  assign edges_accepted = edges_accepted_q;
  assign overflow_err   = overflow_err_q;

`ifdef BCR_DISPATCH_CONFLICT_CHECK_EN
  logic conflict_hit;
  logic conflict_err_q, conflict_err_d;

  always_comb begin
    conflict_hit = 1'b0;
    for (int i = 0; i < LANES - 1; i++) begin
      for (int j = i + 1; j < LANES; j++) begin
        if (lane_valid[i] && lane_valid[j] &&
            (bank_of(lane_edge[i]) == bank_of(lane_edge[j]))) begin
          conflict_hit = 1'b1;
        end
      end
    end
    conflict_err_d = conflict_err_q | conflict_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_err_q <= 1'b0;
    end else begin
      conflict_err_q <= conflict_err_d;
    end
  end

  assign conflict_err = conflict_err_q;
`else
  assign conflict_err = 1'b0;
`endif

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    bcr_bank_fifo #(
      .WIDTH (EDGE_W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_accept[b]),
      .wr_data (wr_edge[b]),
      .rd_en   (rd_pop[b]),
      .rd_data (fifo_data[b]),
      .empty   (fifo_empty[b]),
      .full    (fifo_full[b]),
      .count   (fifo_count[b])
    );

    assign bank_data[EDGE_W*b +: EDGE_W] = fifo_data[b];
  end

endmodule

// File: tb/tb_bcr_bank_dispatcher_x8.sv
// Randomised and directed bench for bcr_bank_dispatcher_x8 against a queue-based bank model.
// Honours BCR_DISPATCH_CONFLICT_CHECK_EN for the expected conflict_err value.
module tb_bcr_bank_dispatcher_x8;
  import bcr_pkg::*;

  localparam int DEPTH        = 16;
  localparam int STALL_MARGIN = 2;
  localparam int LW           = LANES * EDGE_W;

  logic                        clk;
  logic                        rst;
  logic [LW-1:0]               lane_data;
  logic [LANES-1:0]            lane_valid;
  logic                        stall;
  logic [NUM_BANKS*EDGE_W-1:0] bank_data;
  logic [NUM_BANKS-1:0]        bank_valid;
  logic [NUM_BANKS-1:0]        bank_ready;
  logic [31:0]                 edges_accepted;
  logic                        overflow_err;
  logic                        conflict_err;

  edge_t       m_q [NUM_BANKS][$];
  logic [31:0] m_edges;
  logic        m_ovf;
  logic        m_conf;
  int          checks;
  int          errors;

  bcr_bank_dispatcher_x8 #(
    .DEPTH        (DEPTH),
    .STALL_MARGIN (STALL_MARGIN)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .lane_data      (lane_data),
    .lane_valid     (lane_valid),
    .stall          (stall),
    .bank_data      (bank_data),
    .bank_valid     (bank_valid),
    .bank_ready     (bank_ready),
    .edges_accepted (edges_accepted),
    .overflow_err   (overflow_err),
    .conflict_err   (conflict_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic edge_t mk_edge(input int bank);
    edge_t e;
    e = {$urandom, $urandom, $urandom};
    e[BANK_W-1:0] = bank_idx_t'(bank);
    return e;
  endfunction

  // Bank model: each FIFO is a queue; lowest matching lane wins, a full queue takes a write only alongside a pop.
  task automatic stepModel(input logic r, input logic [LANES-1:0] v, input logic [LW-1:0] d,
                           input logic [NUM_BANKS-1:0] rdy);
    int    hits;
    bit    pop;
    bit    was_full;
    edge_t e;
    edge_t sel;
    int    acc;
    if (r) begin
      for (int b = 0; b < NUM_BANKS; b++) m_q[b].delete();
      m_edges = '0;
      m_ovf   = 1'b0;
      m_conf  = 1'b0;
      return;
    end
    acc = 0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      hits = 0;
      sel  = '0;
      for (int i = 0; i < LANES; i++) begin
        e = d[EDGE_W*i +: EDGE_W];
        if (v[i] && (int'(e[BANK_W-1:0]) == b)) begin
          if (hits == 0) sel = e;
          hits++;
        end
      end
      pop      = (m_q[b].size() > 0) && rdy[b];
      was_full = (m_q[b].size() == DEPTH);
      if (pop) void'(m_q[b].pop_front());
      if (hits > 0) begin
        if (!was_full || pop) begin
          m_q[b].push_back(sel);
          acc++;
        end else begin
          m_ovf = 1'b1;
        end
      end
`ifdef BCR_DISPATCH_CONFLICT_CHECK_EN
      if (hits > 1) m_conf = 1'b1;
`endif
    end
    m_edges = m_edges + 32'(acc);
  endtask

  task automatic checkAll(input string phase);
    logic [NUM_BANKS-1:0]        exp_valid;
    logic [NUM_BANKS*EDGE_W-1:0] exp_data;
    logic                        exp_stall;
    exp_valid = '0;
    exp_data  = '0;
    exp_stall = 1'b0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (m_q[b].size() > 0) begin
        exp_valid[b] = 1'b1;
        exp_data[EDGE_W*b +: EDGE_W] = m_q[b][0];
      end
      if (m_q[b].size() >= DEPTH - STALL_MARGIN) exp_stall = 1'b1;
    end
    checkOutput({phase, ".bank_valid"},     LW'(bank_valid),     LW'(exp_valid));
    checkOutput({phase, ".bank_data"},      LW'(bank_data),      LW'(exp_data));
    checkOutput({phase, ".stall"},          LW'(stall),          LW'(exp_stall));
    checkOutput({phase, ".edges_accepted"}, LW'(edges_accepted), LW'(m_edges));
    checkOutput({phase, ".overflow_err"},   LW'(overflow_err),   LW'(m_ovf));
    checkOutput({phase, ".conflict_err"},   LW'(conflict_err),   LW'(m_conf));
  endtask

  // Drives one cycle of inputs from a negedge, advances the model at the posedge, checks at the next negedge.
  task automatic applyStimulus(input string phase, input logic r, input logic [LANES-1:0] v,
                               input logic [LW-1:0] d, input logic [NUM_BANKS-1:0] rdy);
    rst        = r;
    lane_valid = v;
    lane_data  = d;
    bank_ready = rdy;
    @(posedge clk);
    stepModel(r, v, d, rdy);
    @(negedge clk);
    checkAll(phase);
  endtask

  task automatic idle(input string phase, input logic [NUM_BANKS-1:0] rdy);
    applyStimulus(phase, 1'b0, '0, '0, rdy);
  endtask

  function automatic logic [LW-1:0] one_lane(input int lane, input int bank);
    logic [LW-1:0] d;
    d = '0;
    d[EDGE_W*lane +: EDGE_W] = mk_edge(bank);
    return d;
  endfunction

  function automatic logic [LW-1:0] all_banks();
    logic [LW-1:0] d;
    for (int i = 0; i < LANES; i++) d[EDGE_W*i +: EDGE_W] = mk_edge(i);
    return d;
  endfunction

  initial begin
    logic [LW-1:0]        d;
    logic [LANES-1:0]     v;
    logic [NUM_BANKS-1:0] rdy;
    checks = 0;
    errors = 0;
    m_edges = '0;
    m_ovf   = 1'b0;
    m_conf  = 1'b0;

    applyStimulus("reset", 1'b1, '0, '0, '0);
    applyStimulus("reset", 1'b1, '0, '0, '0);

    applyStimulus("all_banks", 1'b0, 8'hFF, all_banks(), 8'hFF);
    idle("all_banks_drain", 8'hFF);

    for (int n = 0; n < 16; n++) applyStimulus("stall_fill", 1'b0, 8'h01, one_lane(0, 3), 8'hF7);
    idle("stall_pop", 8'h08);
    idle("stall_pop", 8'h08);
    idle("stall_drain", 8'hFF);
    for (int n = 0; n < 16; n++) idle("stall_drain", 8'hFF);

    for (int n = 0; n < DEPTH; n++) applyStimulus("full5_fill", 1'b0, 8'h10, one_lane(4, 5), 8'hDF);
    applyStimulus("full5_rdwr", 1'b0, 8'h04, one_lane(2, 5), 8'hFF);
    for (int n = 0; n < DEPTH + 2; n++) idle("full5_drain", 8'hFF);
    for (int n = 0; n < DEPTH; n++) applyStimulus("full5_refill", 1'b0, 8'h10, one_lane(4, 5), 8'hDF);
    applyStimulus("full5_drop", 1'b0, 8'h01, one_lane(0, 5), 8'hDF);
    for (int n = 0; n < DEPTH; n++) idle("full5_drain2", 8'hFF);

    d = one_lane(2, 4) | one_lane(6, 4);
    applyStimulus("conflict", 1'b0, 8'h44, d, 8'h00);
    idle("conflict_pop", 8'hFF);

    for (int n = 0; n < 5; n++) begin
      d = one_lane(0, 0) | one_lane(1, 1);
      applyStimulus("rst_fill", 1'b0, 8'h03, d, 8'h00);
    end
    applyStimulus("rst_mid", 1'b1, 8'h03, d, 8'h00);
    applyStimulus("rst_fresh", 1'b0, 8'h80, one_lane(7, 6), 8'h00);
    idle("rst_fresh_pop", 8'hFF);

    applyStimulus("wrap_pre", 1'b1, '0, '0, '0);
    force dut.edges_accepted_q = 32'hFFFF_FFFD;
    #1;
    release dut.edges_accepted_q;
    m_edges = 32'hFFFF_FFFD;
    applyStimulus("wrap", 1'b0, 8'hFF, all_banks(), 8'hFF);
    checkOutput("wrap_value", LW'(edges_accepted), LW'(32'd5));
    idle("wrap_drain", 8'hFF);

    for (int n = 0; n < 600; n++) begin
      d = '0;
      for (int i = 0; i < LANES; i++) d[EDGE_W*i +: EDGE_W] = mk_edge(int'($urandom_range(0, NUM_BANKS - 1)));
      v = 8'($urandom);
      if (n >= 300 && stall) v = '0;
      rdy = '0;
      for (int b = 0; b < NUM_BANKS; b++) rdy[b] = ($urandom_range(0, 99) < ((n < 300) ? 35 : 75));
      applyStimulus("random", ($urandom_range(0, 149) == 0), v, d, rdy);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcr_bank_dispatcher_x8.md
Name: bcr_bank_dispatcher_x8

Overview:
- Consumer end of the 8-lane bank-conflict-resolver interface.
- Takes the 8 per-lane edge/valid outputs and routes each valid edge to its target memory bank. The bank is the low BANK_W bits of the edge.
- Buffers edges in one FIFO per bank and drives a per-bank valid/ready interface toward the bank update units.
- Generates the `stall` that the resolver consumes, and counts accepted edges.

Parameters:
- EDGE_W, 96, width of one edge word.
- BANK_W, 3, bank-select width; NUM_BANKS = 2**BANK_W = 8; bank index = edge[BANK_W-1:0].
- DEPTH, 16, entries per bank FIFO; power of two, minimum 4.
- STALL_MARGIN, 2, free-slot headroom at which `stall` asserts; 1 <= STALL_MARGIN < DEPTH.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- lane_data  in  8*EDGE_W  lane i edge at [EDGE_W*(i+1)-1 : EDGE_W*i].
- lane_valid  in  8  per-lane valid, bit i for lane i.
- stall  out  1  backpressure to the resolver.
- bank_data  out  NUM_BANKS*EDGE_W  FIFO head per bank, same packing as lane_data.
- bank_valid  out  NUM_BANKS  FIFO b non-empty.
- bank_ready  in  NUM_BANKS  consumer accepts the bank b head.
- edges_accepted  out  32  running count of edges written to FIFOs.
- overflow_err  out  1  sticky: write dropped on a full FIFO.
- conflict_err  out  1  sticky: two valid lanes targeted the same bank in one cycle (optional feature).

Behaviour:
- Reset: all FIFOs empty (pointers and counts 0); bank_valid=0; bank_data=0; stall=0; edges_accepted=0; overflow_err=0; conflict_err=0. Reset mid-operation discards all buffered edges in the same cycle.
- Routing, combinational, per bank b:
  - Select the lowest-index lane i with lane_valid[i]=1 and lane_data_i[BANK_W-1:0]==b.
  - Write request wr[b] = a lane was selected.
  - Non-selected lanes targeting the same bank are dropped. This only occurs on a protocol violation; see the optional feature.
- Write:
  - If wr[b] and (count[b]<DEPTH, or a read of bank b occurs in the same cycle), the edge is enqueued at the rising edge.
  - If wr[b] with count[b]==DEPTH and no same-cycle read: edge dropped, overflow_err<=1.
- Read:
  - FIFO is first-word-fall-through; bank_data[b] shows the head whenever bank_valid[b]=1.
  - A pop occurs when bank_valid[b] && bank_ready[b].
  - Read of an empty FIFO is ignored.
- Latency: a lane write sampled in cycle N appears on bank_valid/bank_data in cycle N+1. There is no same-cycle bypass.
- Simultaneous read and write:
  - On empty: write accepted, count goes 0->1, bank_valid=1 next cycle.
  - On full: both proceed, count stays DEPTH.
- Count update: count[b] += wr_accepted - rd.
- Pointers: log2(DEPTH) bits, natural wrap at DEPTH.
- stall: combinational = OR over b of (count[b] >= DEPTH-STALL_MARGIN), computed from registered counts. This guarantees no overflow given the resolver's one-cycle stall reaction.
- edges_accepted: adds popcount of accepted writes each cycle (0..8); wraps modulo 2**32.
- Error flags: cleared only by rst.

Optional Feature:
- Macro: BCR_DISPATCH_CONFLICT_CHECK_EN.
- Defined:
  - Each cycle, compare the bank fields of all valid lane pairs (28 comparators).
  - On any match, set conflict_err<=1 (sticky). Routing still takes the lowest index.
- Undefined: conflict_err tied to 0; no comparators instantiated.

Decomposition:
- Shared package bcr_pkg:
  - constants LANES=8, EDGE_W, BANK_W, NUM_BANKS;
  - typedef edge_t (logic [EDGE_W-1:0]);
  - typedef bank_idx_t (logic [BANK_W-1:0]);
  - function bank_of(edge_t) returning the low BANK_W bits.
- One sub-module: bcr_bank_fifo.
  - Parameterised on width and depth.
  - FWFT; exposes wr_en, wr_data, rd_en, rd_data, empty, full, count.
  - Instantiated NUM_BANKS times in a generate loop.
- Routing mux, stall, counter and error logic stay in the top.

Test Plan:
- Lanes 0..7 carry edges with banks 0..7, all valid, all bank_ready=1 -> next cycle bank_valid=8'hFF, bank_data[b] equals the lane-b edge; edges_accepted=8; stall=0.
- bank_ready[3]=0; drive one bank-3 edge per cycle with DEPTH=16, STALL_MARGIN=2 -> stall rises the cycle count[3] reaches 14; stall deasserted on any bank_ready[3] pop dropping count to 13; overflow_err stays 0.
- Force FIFO 5 full (16 entries); same cycle: lane edge to bank 5 and bank_ready[5]=1 -> count stays 16; FIFO order intact (pop 17 words, values in FIFO order); overflow_err=0. Repeat with bank_ready[5]=0 -> edge dropped, overflow_err=1.
- Lanes 2 and 6 both valid, both bank 4 -> only the lane-2 edge enqueued; edges_accepted +1; conflict_err=1 with macro, 0 without.
- Fill banks 0,1 with 5 entries each, assert rst for one cycle -> next cycle bank_valid=0, stall=0, edges_accepted=0; a fresh write appears after 1 cycle.
- Run 2**32-3 accepted edges (preload counter via force), then 8-edge cycle -> edges_accepted wraps to 5.
